// File: rtl/imem_uart_loader_pkg.sv
// imem_uart_loader_pkg: shared types and constants for the UART program loader.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CHK state).
package imem_uart_loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE, S_ERROR
  } state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_LOADING = 2'b01;
  localparam logic [1:0] ST_DONE    = 2'b10;
  localparam logic [1:0] ST_ERROR   = 2'b11;
  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  function automatic logic [1:0] status_of(state_t s);
    return s == S_IDLE ? ST_IDLE : s == S_DONE ? ST_DONE : s == S_ERROR ? ST_ERROR : ST_LOADING;
  endfunction
endpackage

// File: rtl/imem_uart_loader_uart_rx_byte.sv
// uart_rx_byte: 8N1 receiver with 2-FF synchronizer and glitch-rejecting start detect.
// Ports: clk, rst_n (async active-low), rx (serial in), rx_data (received byte),
// rx_valid (one-cycle pulse after stop-bit sample), rx_frame_err (stop bit was low, qualifies rx_valid).
module uart_rx_byte
  import imem_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  rx_state_t rs_q, rs_d;
  logic [2:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic valid_q, valid_d, err_q, err_d;
  // sync_q[1] is the synchronized line, sync_q[2] its previous value for edge detection
  logic rx_s, fall;
  assign rx_s = sync_q[1];
  assign fall = sync_q[2] & ~rx_s;
  always_comb begin
    rs_d = rs_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    sh_d = sh_q;
    valid_d = 1'b0;
    err_d = err_q;
    case (rs_q)
      R_IDLE: if (fall) begin
        rs_d = R_START;
        cnt_d = '0;
      end
      R_START: if (cnt_q == HALF_M1) begin
        rs_d = rx_s ? R_IDLE : R_DATA;
        cnt_d = '0;
        bit_d = '0;
      end else cnt_d = cnt_q + 1'b1;
      R_DATA: if (cnt_q == FULL_M1) begin
        sh_d = {rx_s, sh_q[7:1]};
        cnt_d = '0;
        bit_d = bit_q + 1'b1;
        rs_d = bit_q == 3'd7 ? R_STOP : R_DATA;
      end else cnt_d = cnt_q + 1'b1;
      default: if (cnt_q == FULL_M1) begin
        rs_d = R_IDLE;
        valid_d = 1'b1;
        err_d = ~rx_s;
      end else cnt_d = cnt_q + 1'b1;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q <= R_IDLE;
      sync_q <= 3'b111;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rs_q <= rs_d;
      sync_q <= {sync_q[1:0], rx};
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  end
  assign rx_data = sh_q;
  assign rx_valid = valid_q;
  assign rx_frame_err = err_q;
endmodule

// File: rtl/imem_uart_loader.sv
// imem_uart_loader: loads a framed program over UART into instruction memory, holding the CPU in reset.
// Ports: clk, rst_n (async active-low), uart_rx, load_en (session level), imem_we/imem_waddr/imem_wdata
// (memory write port), cpu_rst_n (CPU hold), status (00 idle/01 loading/10 done/11 error), word_count.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  input  logic              load_en,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic [1:0]        status,
  output logic [15:0]       word_count
);
  localparam logic [16:0] MAX_N = 17'd1 << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CHK;
  logic [7:0] xor_q, xor_d;
`else
  localparam state_t S_FIN = S_DONE;
`endif
  logic [7:0] rx_data;
  logic rx_valid, rx_frame_err;
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk), .rst_n(rst_n), .rx(uart_rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err)
  );
  state_t state_q, state_d;
  logic [15:0] len_q, len_d, cnt_q, cnt_d, n_rx;
  logic [1:0] idx_q, idx_d, status_q, status_d;
  logic [31:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic we_q, we_d, cpu_q, cpu_d, byte_ok, bad;
  assign byte_ok = rx_valid & ~rx_frame_err;
  assign bad = rx_valid & rx_frame_err;
  assign n_rx = {rx_data, len_q[7:0]};
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    idx_d = idx_q;
    wdata_d = wdata_q;
    we_d = 1'b0;
    // address and count advance on the edge that ends the strobe
    waddr_d = we_q ? waddr_q + 1'b1 : waddr_q;
    cnt_d = we_q ? cnt_q + 16'd1 : cnt_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d = xor_q;
`endif
    case (state_q)
      S_IDLE: begin
        waddr_d = '0;
        cnt_d = '0;
        idx_d = '0;
        state_d = load_en ? S_SYNC : S_IDLE;
      end
      S_SYNC: begin
`ifdef LOADER_CHECKSUM_EN
        xor_d = '0;
`endif
        if (byte_ok && rx_data == SYNC_BYTE) state_d = S_LEN_LO;
      end
      S_LEN_LO: if (bad) state_d = S_ERROR;
      else if (byte_ok) begin
        len_d[7:0] = rx_data;
        state_d = S_LEN_HI;
      end
      S_LEN_HI: if (bad) state_d = S_ERROR;
      else if (byte_ok) begin
        len_d[15:8] = rx_data;
        state_d = {1'b0, n_rx} > MAX_N ? S_ERROR : n_rx == 16'd0 ? S_FIN : S_DATA;
      end
      S_DATA: begin
        if (bad) state_d = S_ERROR;
        else if (byte_ok) begin
          wdata_d[8*idx_q +: 8] = rx_data;
          idx_d = idx_q + 1'b1;
          we_d = idx_q == 2'd3;
`ifdef LOADER_CHECKSUM_EN
          xor_d = xor_q ^ rx_data;
`endif
        end
        if (we_q && cnt_q + 16'd1 == len_q) state_d = S_FIN;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: if (rx_valid) state_d = byte_ok && rx_data == xor_q ? S_DONE : S_ERROR;
`endif
      default: state_d = state_q;
    endcase
    // dropping load_en wins over everything, including a byte arriving this cycle
    if (!load_en) begin
      state_d = S_IDLE;
      we_d = 1'b0;
    end
    status_d = status_of(state_d);
    cpu_d = state_d == S_IDLE || state_d == S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      we_q <= 1'b0;
      cpu_q <= 1'b0;
      status_q <= ST_IDLE;
`ifdef LOADER_CHECKSUM_EN
      xor_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      we_q <= we_d;
      cpu_q <= cpu_d;
      status_q <= status_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q <= xor_d;
`endif
    end
  end
  assign imem_we = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst_n = cpu_q;
  assign status = status_q;
  assign word_count = cnt_q;
endmodule
